// File: rtl/wr_ingress_if.sv
// Producer-side valid/ready stream into the write-domain ingress.
// master = producer, slave = ingress controller.
interface wr_ingress_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready
  );
endinterface

// File: rtl/wr_ingress_ctrl.sv
// Async FIFO write-domain ingress: 2-entry skid buffer, frame counter,
// stall watchdog. Optional WR_PARITY_EN appends even parity to w_data.
module wr_ingress_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_WIDTH   = 16,
`ifdef WR_PARITY_EN
  localparam int OW = DATA_WIDTH + 1
`else
  localparam int OW = DATA_WIDTH
`endif
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  wr_ingress_if.slave          s,
  input  logic                 full,
  output logic                 w_en,
  output logic [OW-1:0]        w_data,
  output logic                 w_last,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 stall_err,
  input  logic                 clr_err
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STALLED
  } state_t;

  state_t                state;
  logic                  h_valid;
  logic                  h_last;
  logic [OW-1:0]         h_data;
  logic                  k_valid;
  logic                  k_last;
  logic [DATA_WIDTH-1:0] k_data;
  logic [OW-1:0]         o_data;
  logic                  o_last;
  logic [SW-1:0]         stall_cnt;
  logic                  acc;
  logic                  stall;
  logic                  h_valid_n;

  function automatic logic [OW-1:0] enc(
    input logic [DATA_WIDTH-1:0] d
  );
`ifdef WR_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign s.s_ready = !k_valid;
  assign acc       = s.s_valid & !k_valid;
  assign w_en      = h_valid & !full;
  assign stall     = (state != IDLE) & full;
  // Outputs show the head word while writing, else the last written word
  assign w_data    = w_en ? h_data : o_data;
  assign w_last    = w_en ? h_last : o_last;

  always_comb begin
    h_valid_n = h_valid;
    if (w_en)
      h_valid_n = k_valid | acc;
    else if (!h_valid)
      h_valid_n = acc;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      h_valid   <= 1'b0;
      h_last    <= 1'b0;
      h_data    <= '0;
      k_valid   <= 1'b0;
      k_last    <= 1'b0;
      k_data    <= '0;
      o_data    <= '0;
      o_last    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      h_valid <= h_valid_n;
      if (w_en) begin
        o_data <= h_data;
        o_last <= h_last;
      end
      if (w_en && h_last)
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      // acc implies K empty, so K->H and producer->K never collide
      if (w_en && k_valid) begin
        h_data  <= enc(k_data);
        h_last  <= k_last;
        k_valid <= 1'b0;
      end else if (acc && (w_en || !h_valid)) begin
        h_data <= enc(s.s_data);
        h_last <= s.s_last;
      end else if (acc) begin
        k_data  <= s.s_data;
        k_last  <= s.s_last;
        k_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      unique case (1'b1)
        !h_valid_n:         state <= IDLE;
        h_valid_n && full:  state <= STALLED;
        h_valid_n && !full: state <= ACTIVE;
      endcase
      if (!stall)
        stall_cnt <= '0;
      else if (stall_cnt != SW'(STALL_LIMIT))
        stall_cnt <= stall_cnt + SW'(1);
      if (stall && stall_cnt >= SW'(STALL_LIMIT - 1))
        stall_err <= 1'b1;
      else if (clr_err)
        stall_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Directed bench for wr_ingress_ctrl; a second instance with
// CNT_WIDTH=2 checks frame counter wrap.
module tb_wr_ingress_ctrl;

`ifdef WR_PARITY_EN
  localparam int OW = 9;
`else
  localparam int OW = 8;
`endif

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        full = 1'b0;
  logic        clr_err = 1'b0;

  logic          w_en, w_en2;
  logic [OW-1:0] w_data, w_data2;
  logic          w_last, w_last2;
  logic [15:0]   frame_cnt;
  logic [1:0]    frame_cnt2;
  logic          stall_err, stall_err2;

  int nvec = 0;
  int nerr = 0;

  wr_ingress_if #(.DATA_WIDTH(8)) p1 ();
  wr_ingress_if #(.DATA_WIDTH(8)) p2 ();

  assign p1.s_valid = s_valid;
  assign p1.s_data  = s_data;
  assign p1.s_last  = s_last;
  assign p2.s_valid = s_valid;
  assign p2.s_data  = s_data;
  assign p2.s_last  = s_last;

  wr_ingress_ctrl #(
    .DATA_WIDTH(8), .STALL_LIMIT(16), .CNT_WIDTH(16)
  ) u_dut (
    .wclk(wclk), .wrst_n(wrst_n), .s(p1.slave),
    .full(full), .w_en(w_en), .w_data(w_data),
    .w_last(w_last), .frame_cnt(frame_cnt),
    .stall_err(stall_err), .clr_err(clr_err)
  );

  wr_ingress_ctrl #(
    .DATA_WIDTH(8), .STALL_LIMIT(16), .CNT_WIDTH(2)
  ) u_dut2 (
    .wclk(wclk), .wrst_n(wrst_n), .s(p2.slave),
    .full(full), .w_en(w_en2), .w_data(w_data2),
    .w_last(w_last2), .frame_cnt(frame_cnt2),
    .stall_err(stall_err2), .clr_err(clr_err)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] fr_data [5];
  logic [31:0] fr_wexp [5];
  logic [31:0] fr_c16  [5];
  logic [31:0] fr_c2   [5];

  initial begin
    fr_data = '{32'h07, 32'h03, 32'h5A, 32'hFF, 32'h80};
`ifdef WR_PARITY_EN
    fr_wexp = '{32'h107, 32'h003, 32'h05A, 32'h0FF, 32'h180};
`else
    fr_wexp = '{32'h07, 32'h03, 32'h5A, 32'hFF, 32'h80};
`endif
    fr_c16 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    fr_c2  = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

    // reset
    #1 wrst_n = 1'b0;
    #2;
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_w_last", 32'(w_last), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_stall_err", 32'(stall_err), 32'd0);
    tick();
    wrst_n = 1'b1;
    tick();
    chk("rel_s_ready", 32'(p1.s_ready), 32'd1);

    // back-to-back stream 11,22,33
    s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
    #1;
    chk("t1_c0_w_en", 32'(w_en), 32'd0);
    tick();
    s_data = 8'h22;
    #1;
    chk("t1_c1_w_en", 32'(w_en), 32'd1);
    chk("t1_c1_w_data", 32'(w_data), 32'h11);
    tick();
    s_data = 8'h33; s_last = 1'b1;
    #1;
    chk("t1_c2_w_en", 32'(w_en), 32'd1);
    chk("t1_c2_w_data", 32'(w_data), 32'h22);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("t1_c3_w_en", 32'(w_en), 32'd1);
    chk("t1_c3_w_data", 32'(w_data), 32'h33);
    chk("t1_c3_w_last", 32'(w_last), 32'd1);
    tick();
    chk("t1_c4_w_en", 32'(w_en), 32'd0);
    chk("t1_hold_data", 32'(w_data), 32'h33);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // back-pressure fills H and K
    full = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
    #1;
    chk("t2_c0_ready", 32'(p1.s_ready), 32'd1);
    tick();
    s_data = 8'hA1;
    #1;
    chk("t2_c1_ready", 32'(p1.s_ready), 32'd1);
    chk("t2_c1_w_en", 32'(w_en), 32'd0);
    tick();
    s_data = 8'hA2;
    #1;
    chk("t2_c2_ready", 32'(p1.s_ready), 32'd0);
    chk("t2_c2_w_en", 32'(w_en), 32'd0);
    tick();
    full = 1'b0; s_valid = 1'b0;
    #1;
    chk("t2_c3_w_en", 32'(w_en), 32'd1);
    chk("t2_c3_w_data", 32'(w_data), 32'hA0);
    tick();
    chk("t2_c4_w_en", 32'(w_en), 32'd1);
    chk("t2_c4_w_data", 32'(w_data), 32'hA1);
    chk("t2_c4_ready", 32'(p1.s_ready), 32'd1);
    tick();
    chk("t2_c5_w_en", 32'(w_en), 32'd0);
    chk("t2_c5_hold", 32'(w_data), 32'hA1);

    // stall watchdog
    full = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) chk("t3_err_c16", 32'(stall_err), 32'd0);
      tick();
    end
    chk("t3_err_set", 32'(stall_err), 32'd1);
    full = 1'b0;
    #1;
    chk("t3_w_en", 32'(w_en), 32'd1);
    chk("t3_w_data", 32'(w_data), 32'h55);
    tick();
    chk("t3_err_sticky", 32'(stall_err), 32'd1);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_err_clr", 32'(stall_err), 32'd0);

    // reset with both slots occupied
    full = 1'b1; s_valid = 1'b1; s_data = 8'h66;
    tick();
    s_data = 8'h77;
    tick();
    chk("t4_ready_low", 32'(p1.s_ready), 32'd0);
    #2 wrst_n = 1'b0;
    #1;
    chk("t4_w_en", 32'(w_en), 32'd0);
    chk("t4_w_data", 32'(w_data), 32'd0);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd0);
    full = 1'b0; s_valid = 1'b0;
    #1;
    chk("t4_w_en_rst", 32'(w_en), 32'd0);
    tick();
    wrst_n = 1'b1;
    tick();
    chk("t4_ready", 32'(p1.s_ready), 32'd1);
    chk("t4_discard", 32'(w_en), 32'd0);
    chk("t4_cnt_post", 32'(frame_cnt), 32'd0);

    // single-word frames: counter wrap and parity
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = fr_data[i][7:0]; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      #1;
      chk("t5_w_data", 32'(w_data), fr_wexp[i]);
      tick();
      chk("t5_cnt16", 32'(frame_cnt), fr_c16[i]);
      chk("t5_cnt2", 32'(frame_cnt2), fr_c2[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule
